// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB4 master bridge: FSM state encoding,
// PPROT attribute bits and the command record used by command sources.
package apb_master_bridge_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    // State encoding, kept as plain constants so older tools and checkers can bind to it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } apb_master_state_t;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
        logic [2:0]        prot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB4 pin bundle of the bridge. The master modport is the
// bridge's view; the slave modport is the view of whatever surrounds it.
interface apb_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8
);
    // Handshakes: a beat transfers on the rising PCLK edge where valid && ready;
    // once raised, valid and its payload stay stable until that edge.
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;

    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PNSE;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge_timeout_counter.sv
// Counts ACCESS cycles of one APB transfer; expire_o flags the last cycle
// the bridge is willing to wait for PREADY.
module apb_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: takes one command at a time, runs a SETUP/ACCESS transfer and
// returns read data, slave error or timeout on the response channel.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus,
    output apb_master_state_t   dbg_state_o
);
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic [2:0]    pprot_q, pprot_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          slverr_q, slverr_d;
    logic          timeout_q, timeout_d;
    logic          expire;
    logic          accept;

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

    apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .clear_i  (state_q == ST_SETUP),
        .enable_i (state_q == ST_ACCESS),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SETUP;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    // Reads never carry strobes on APB4.
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
                    pprot_d  = bus.cmd_prot;
                    pwrite_d = bus.cmd_write;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // PREADY wins over expiry when both land in the same cycle.
                if (bus.PREADY) begin
                    state_d   = ST_RESP;
                    rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    slverr_d  = bus.PSLVERR;
                    timeout_d = 1'b0;
                end else if (expire) begin
                    state_d   = ST_RESP;
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    // Handshake and bus-phase outputs decode straight from the state register.
    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_slverr  = slverr_q;
    assign bus.rsp_timeout = timeout_q;

    assign bus.PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.PENABLE = (state_q == ST_ACCESS);
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PPROT   = pprot_q;
    assign bus.PNSE    = 1'b0;

    assign dbg_state_o = apb_master_state_t'(state_q);

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester. Converts a simple valid/ready command channel into APB4 SETUP/ACCESS transfers, one at a time.
- Returns each completion (read data, slave error, timeout) on a valid/ready response channel.
- Sits between the test/CPU-side command source and the APB slave memory block; its APB pins connect 1:1 to the slave's PADDR..PREADY.

Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- SW, DW/8, strobe width
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (>=2)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  byte address
- cmd_wdata  in  DW  write data
- cmd_strb  in  SW  byte strobes (writes)
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DW  read data (0 for writes/timeouts)
- rsp_slverr  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  AW
- PPROT  out  3
- PNSE  out  1  constant 0
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DW
- PSTRB  out  SW
- PREADY  in  1
- PRDATA  in  DW
- PSLVERR  in  1

Behaviour:
- One clock (PCLK); reset asynchronous, active-low (PRESETn).
- Reset values:
  - State = IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, PSTRB, PPROT = 0.
  - rsp_valid = 0; rsp_* data = 0; timeout counter = 0.
- All outputs are registered or decoded directly from the state register; no combinational path from PREADY to any output.
- States: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/strb/prot/write → SETUP.
  - SETUP: lasts exactly 1 cycle; PSEL=1, PENABLE=0; APB address/control/data driven from latched values → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; all APB outputs stable; counter increments each cycle.
    - PREADY=1 sampled: capture PRDATA (reads only, else 0) and PSLVERR → RESP.
    - Counter reaches TIMEOUT-1 with PREADY=0: rsp_slverr=1, rsp_timeout=1, rdata=0 → RESP.
  - RESP: PSEL=PENABLE=0; rsp_valid=1, held with stable data until rsp_ready → IDLE.
- cmd_ready=0 in SETUP, ACCESS and RESP. Single outstanding transfer; no back-to-back APB transfers.
- PSTRB is forced to 0 on reads (APB4 rule), regardless of cmd_strb.
- Latency: command accepted at edge N → SETUP in cycle N+1 → ACCESS from N+2. With zero wait states, rsp_valid rises in N+3. Each added wait cycle adds 1.
- A PREADY sampled high in the same cycle the counter hits TIMEOUT-1 counts as normal completion, not a timeout.
- PREADY/PSLVERR are ignored outside ACCESS.
- Reset asserted mid-transfer: PSEL/PENABLE/rsp_valid drop immediately (async); the transfer is lost and not replayed.
- Counter width = $clog2(TIMEOUT); cleared on entry to SETUP.

Decomposition:
- apb_pkg: apb_master_state_t enum (IDLE/SETUP/ACCESS/RESP), APB4 PPROT bit constants, a cmd struct typedef (write, addr, wdata, strb, prot).
- One sub-module is natural: apb_timeout_counter (clear, enable, expire output). Everything else stays in apb_master_bridge.

Test Plan:
- Write addr 0x10, wdata 0xDEADBEEF, strb 0xF, zero-wait responder → PSEL in cycle N+1, PENABLE in N+2; rsp_valid in N+3 with slverr=0, timeout=0.
- Read addr 0x10 after the write, responder with 2 wait states and PRDATA 0xDEADBEEF → rsp_rdata=0xDEADBEEF in N+5; PSTRB=0 throughout.
- Write to 0x4000, responder returns PSLVERR=1 → rsp_slverr=1, rsp_timeout=0, rsp_rdata=0.
- Responder never asserts PREADY, TIMEOUT=16 → ACCESS lasts exactly 16 cycles; rsp_slverr=1, rsp_timeout=1; then PSEL=0.
- rsp_ready held 0 for 5 cycles with cmd_valid high → rsp_valid and data stable, cmd_ready=0; accept a new command the cycle after the handshake.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE=0 asynchronously; after release, IDLE with cmd_ready=1 and no response emitted.
